// File: rtl/mp_add_sequencer.sv
// Multi-precision adder sequencer: streams NUM_WORDS operand words LSW first
// through one shared adder_nbit and carries the inter-word carry in a register.

module adder_nbit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
endmodule

module mp_add_sequencer #(
  parameter  int BIT_WIDTH = 4,
  parameter  int NUM_WORDS = 4,
  localparam int IDX_W     = ($clog2(NUM_WORDS) < 1) ? 1 : $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 carry_init,
  input  logic                 abort,
  input  logic                 word_valid,
  input  logic [BIT_WIDTH-1:0] a_word,
  input  logic [BIT_WIDTH-1:0] b_word,
  output logic                 word_req,
  output logic [BIT_WIDTH-1:0] sum_word,
  output logic                 sum_valid,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 carry_out
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 carry_q, carry_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIT_WIDTH-1:0] sum_word_q, sum_word_d;
  logic                 sum_valid_q, sum_valid_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 carry_out_q, carry_out_d;

  logic [BIT_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic                 last_word;

  adder_nbit #(.W(BIT_WIDTH)) u_adder (
    .a        (a_word),
    .b        (b_word),
    .carry_in (carry_q),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_word_d  = sum_word_q;
    sum_valid_d = 1'b0;
    word_idx_d  = word_idx_q;
    done_d      = 1'b0;
    carry_out_d = carry_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          carry_d     = carry_init;
          idx_d       = '0;
          carry_out_d = 1'b0;
          state_d     = S_ADD;
        end
      end
      S_ADD: begin
        // Abort takes priority; a word presented alongside it is not consumed.
        if (abort) begin
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (word_valid) begin
          sum_word_d  = add_sum;
          word_idx_d  = idx_q;
          sum_valid_d = 1'b1;
          carry_d     = add_ovf;
          if (last_word) begin
            carry_out_d = add_ovf;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_word_q  <= '0;
      sum_valid_q <= 1'b0;
      word_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_word_q  <= sum_word_d;
      sum_valid_q <= sum_valid_d;
      word_idx_q  <= word_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign word_req  = (state_q == S_ADD);
  assign sum_word  = sum_word_q;
  assign sum_valid = sum_valid_q;
  assign word_idx  = word_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign carry_out = carry_out_q;

  always @(posedge clk) begin
    if (state_q == S_ADD) begin
      assert (!$isunknown(word_valid))
        else $error("word_valid is X while a word is requested");
      if (word_valid && !abort)
        assert (!$isunknown({a_word, b_word}))
          else $error("a_word/b_word is X on an accepted beat");
    end
  end

endmodule
